lsq_mmio_collector: RTL and testbench

LSQ_MMIO_COLLECTOR -- requirements
Module: lsq_mmio_collector

---
 rtl/lsq_mmio_pkg.sv | 15 +
 rtl/lsq_mmio_collector_if.sv | 43 ++++
 rtl/lsq_mmio_slot_alloc.sv | 37 +++
 rtl/lsq_mmio_collector.sv | 150 +++++++++++++++
 tb/tb_lsq_mmio_collector.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsq_mmio_pkg.sv
// Shared constants and FSM encoding for the LSQ MMIO collector.
// Imported by the collector interface, top and slot allocator.
package lsq_mmio_pkg;

    localparam int DEF_NUM_LANES = 3;
    localparam int DEF_ROB_IDX_W = 8;
    localparam int DEF_DEPTH     = 4;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2
    } mmio_state_t;

endpackage

// File: rtl/lsq_mmio_collector_if.sv
// Handshake bundle between the LSQ/ROB side and the MMIO collector.
// The master drives uops, ROB head info, issue ready and bus response.
interface lsq_mmio_collector_if
    import lsq_mmio_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int ROB_IDX_W = DEF_ROB_IDX_W,
    parameter int DEPTH     = DEF_DEPTH
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [NUM_LANES-1:0]           in_valid;
    logic [NUM_LANES-1:0]           in_mmio;
    logic [NUM_LANES*ROB_IDX_W-1:0] in_rob_idx;
    logic                           in_ready;
    logic                           rob_pending_valid;
    logic [ROB_IDX_W-1:0]           rob_pending_idx;
    logic                           out_valid;
    logic                           out_ready;
    logic [ROB_IDX_W-1:0]           out_rob_idx;
    logic                           resp_valid;
    logic                           flush;
    logic [OCC_W-1:0]               occupancy;
    logic                           overflow_err;

    modport master (
        output in_valid, in_mmio, in_rob_idx,
        output rob_pending_valid, rob_pending_idx,
        output out_ready, resp_valid, flush,
        input  in_ready, out_valid, out_rob_idx,
        input  occupancy, overflow_err
    );

    modport slave (
        input  in_valid, in_mmio, in_rob_idx,
        input  rob_pending_valid, rob_pending_idx,
        input  out_ready, resp_valid, flush,
        output in_ready, out_valid, out_rob_idx,
        output occupancy, overflow_err
    );

endinterface

// File: rtl/lsq_mmio_slot_alloc.sv
// Lane-to-slot mapping: each requesting lane, lowest first, takes the
// lowest slot still free after the lanes before it.
module lsq_mmio_slot_alloc #(
    parameter int NUM_LANES = 3,
    parameter int DEPTH     = 4,
    parameter int LANE_W    = 2
) (
    input  logic [DEPTH-1:0]     free_mask,
    input  logic [NUM_LANES-1:0] lane_req,
    output logic [DEPTH-1:0]     slot_we,
    output logic [LANE_W-1:0]    slot_src [DEPTH]
);

    logic [DEPTH-1:0] avail;
    logic             taken;

    always_comb begin
        avail   = free_mask;
        slot_we = '0;
        taken   = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            slot_src[s] = '0;
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            taken = 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                if (lane_req[i] && !taken && avail[s]) begin
                    avail[s]    = 1'b0;
                    slot_we[s]  = 1'b1;
                    slot_src[s] = LANE_W'(i);
                    taken       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lsq_mmio_collector.sv
// Buffers MMIO uops from the LSQ lanes and issues them one at a time
// when the ROB head reaches them, tracking the single in-flight op.
module lsq_mmio_collector
    import lsq_mmio_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int ROB_IDX_W = DEF_ROB_IDX_W,
    parameter int DEPTH     = DEF_DEPTH
) (
    input logic                 clk,
    input logic                 rst,
    lsq_mmio_collector_if.slave bus
);

    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    mmio_state_t          state, state_n;
    logic [DEPTH-1:0]     slot_valid, valid_n;
    logic [DEPTH-1:0]     slot_issued, issued_n;
    logic [ROB_IDX_W-1:0] slot_idx [DEPTH];
    logic [SLOT_W-1:0]    cur_slot;
    logic [ROB_IDX_W-1:0] issue_idx;
    logic [OCC_W-1:0]     occ, occ_n;
    logic                 ovf;

    logic                 cap_en;
    logic [NUM_LANES-1:0] lane_req;
    logic [DEPTH-1:0]     slot_we;
    logic [LANE_W-1:0]    slot_src [DEPTH];
    logic                 match_hit;
    logic [SLOT_W-1:0]    match_slot;
    logic                 take;
    logic                 resp_free;

    assign bus.in_ready     = (occ <= OCC_W'(DEPTH - NUM_LANES));
    assign bus.out_valid    = (state == S_ISSUE);
    assign bus.out_rob_idx  = issue_idx;
    assign bus.occupancy    = occ;
    assign bus.overflow_err = ovf;

    assign cap_en   = bus.in_ready & ~bus.flush;
    assign lane_req = bus.in_valid & bus.in_mmio & {NUM_LANES{cap_en}};

    lsq_mmio_slot_alloc #(
        .NUM_LANES (NUM_LANES),
        .DEPTH     (DEPTH),
        .LANE_W    (LANE_W)
    ) u_alloc (
        .free_mask (~slot_valid),
        .lane_req  (lane_req),
        .slot_we   (slot_we),
        .slot_src  (slot_src)
    );

    // Descending scan so the lowest matching slot wins.
    always_comb begin
        match_hit  = 1'b0;
        match_slot = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (slot_valid[s] && !slot_issued[s] &&
                slot_idx[s] == bus.rob_pending_idx) begin
                match_hit  = 1'b1;
                match_slot = SLOT_W'(s);
            end
        end
    end

    assign take = (state == S_IDLE) & bus.rob_pending_valid &
                  match_hit & ~bus.flush;
    assign resp_free = (state == S_WAIT_RESP) & bus.resp_valid;

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (take) state_n = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.flush)          state_n = S_IDLE;
                else if (bus.out_ready) state_n = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (bus.resp_valid) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // An op still in ISSUE has not reached the bus, so flush drops it too.
    always_comb begin
        valid_n  = slot_valid;
        issued_n = slot_issued;
        if (bus.flush && state != S_WAIT_RESP) begin
            valid_n  = '0;
            issued_n = '0;
        end else if (bus.flush) begin
            valid_n = slot_valid & slot_issued;
        end
        if (resp_free) begin
            valid_n[cur_slot]  = 1'b0;
            issued_n[cur_slot] = 1'b0;
        end
        if (take) issued_n[match_slot] = 1'b1;
        valid_n = valid_n | slot_we;
    end

    always_comb begin
        occ_n = '0;
        for (int s = 0; s < DEPTH; s++) begin
            occ_n = occ_n + OCC_W'(valid_n[s]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            slot_valid  <= '0;
            slot_issued <= '0;
            cur_slot    <= '0;
            issue_idx   <= '0;
            occ         <= '0;
            ovf         <= 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                slot_idx[s] <= '0;
            end
        end else begin
            state       <= state_n;
            slot_valid  <= valid_n;
            slot_issued <= issued_n;
            occ         <= occ_n;
            if (take) begin
                cur_slot  <= match_slot;
                issue_idx <= slot_idx[match_slot];
            end
            if (|(bus.in_valid & bus.in_mmio) &&
                !bus.in_ready && !bus.flush) begin
                ovf <= 1'b1;
            end
            for (int s = 0; s < DEPTH; s++) begin
                if (slot_we[s]) begin
                    slot_idx[s] <=
                        bus.in_rob_idx[slot_src[s]*ROB_IDX_W +: ROB_IDX_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_lsq_mmio_collector.sv
// Directed bench for lsq_mmio_collector: a queue-based model checked
// every cycle, plus hand-computed literal expectations.
module tb_lsq_mmio_collector;

    localparam int NL = 3;
    localparam int W  = 8;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsq_mmio_collector_if #(.NUM_LANES(NL), .ROB_IDX_W(W), .DEPTH(D)) bus();

    lsq_mmio_collector #(
        .NUM_LANES (NL),
        .ROB_IDX_W (W),
        .DEPTH     (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: un-issued robIdx values as a multiset, plus a phase for the
    // single op between match and response.
    int q[$];
    int m_phase;
    int m_cur;
    bit m_ovf;

    function automatic int m_occ();
        return q.size() + ((m_phase != 0) ? 1 : 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_phase = 0;
            m_cur   = 0;
            m_ovf   = 0;
        end else begin
            automatic bit rdy = (m_occ() <= D - NL);
            automatic logic [NL-1:0] req = bus.in_valid & bus.in_mmio;
            automatic bit found = 0;
            if (req != 0 && !rdy && !bus.flush) m_ovf = 1;
            if (bus.flush) begin
                q.delete();
                if (m_phase == 1) m_phase = 0;
                else if (m_phase == 2 && bus.resp_valid) m_phase = 0;
            end else begin
                case (m_phase)
                    0: if (bus.rob_pending_valid) begin
                        for (int j = 0; j < q.size(); j++) begin
                            if (!found && q[j] == int'(bus.rob_pending_idx)) begin
                                found = 1;
                                m_cur = q[j];
                                q.delete(j);
                                m_phase = 1;
                            end
                        end
                    end
                    1: if (bus.out_ready) m_phase = 2;
                    default: if (bus.resp_valid) m_phase = 0;
                endcase
                if (rdy) begin
                    for (int i = 0; i < NL; i++) begin
                        if (req[i]) q.push_back(int'(bus.in_rob_idx[i*W +: W]));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", int'(bus.out_valid), (m_phase == 1) ? 1 : 0);
        if (m_phase == 1) chk("out_rob_idx", int'(bus.out_rob_idx), m_cur);
        chk("in_ready", int'(bus.in_ready), (m_occ() <= D - NL) ? 1 : 0);
        chk("occupancy", int'(bus.occupancy), m_occ());
        chk("overflow_err", int'(bus.overflow_err), int'(m_ovf));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic lanes(input logic [2:0] v, input logic [2:0] m,
                         input int a, input int b, input int c);
        bus.in_valid   = v;
        bus.in_mmio    = m;
        bus.in_rob_idx = {W'(c), W'(b), W'(a)};
    endtask

    task automatic quiet();
        lanes(3'b000, 3'b000, 0, 0, 0);
        bus.rob_pending_valid = 1'b0;
        bus.out_ready         = 1'b0;
        bus.resp_valid        = 1'b0;
        bus.flush             = 1'b0;
    endtask

    task automatic pend(input int idx);
        bus.rob_pending_valid = 1'b1;
        bus.rob_pending_idx   = W'(idx);
    endtask

    initial begin
        quiet();
        bus.rob_pending_idx = '0;
        step();
        step();
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_rob_idx", int'(bus.out_rob_idx), 0);
        chk("rst_occupancy", int'(bus.occupancy), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_overflow", int'(bus.overflow_err), 0);
        rst = 1'b0;
        step();

        // Lanes 0,2 carry robIdx 5,9; a non-MMIO lane 1 is ignored.
        lanes(3'b111, 3'b101, 5, 77, 9);
        step();
        quiet();
        pend(9);
        chk("cap_occ", int'(bus.occupancy), 2);
        chk("cap_no_valid", int'(bus.out_valid), 0);
        step();
        bus.rob_pending_valid = 1'b0;
        chk("issue_valid", int'(bus.out_valid), 1);
        chk("issue_idx", int'(bus.out_rob_idx), 9);
        chk("issue_occ", int'(bus.occupancy), 2);

        // Back-pressure holds the issue.
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_idx", int'(bus.out_rob_idx), 9);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready  = 1'b0;
        bus.resp_valid = 1'b1;
        chk("wait_valid", int'(bus.out_valid), 0);
        step();
        bus.resp_valid = 1'b0;
        chk("resp_occ", int'(bus.occupancy), 1);

        // Fill to 2, then a 3-lane burst overflows.
        lanes(3'b010, 3'b010, 0, 7, 0);
        step();
        chk("two_occ", int'(bus.occupancy), 2);
        chk("two_ready", int'(bus.in_ready), 0);
        lanes(3'b111, 3'b111, 1, 2, 3);
        step();
        quiet();
        chk("ovf_set", int'(bus.overflow_err), 1);
        chk("ovf_occ", int'(bus.occupancy), 2);

        // Flush in IDLE clears everything.
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_idle_occ", int'(bus.occupancy), 0);

        // Three entries, issue one, flush during WAIT_RESP.
        lanes(3'b111, 3'b111, 20, 21, 22);
        step();
        quiet();
        chk("three_occ", int'(bus.occupancy), 3);
        pend(21);
        step();
        bus.rob_pending_valid = 1'b0;
        chk("issue21", int'(bus.out_rob_idx), 21);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        step();
        bus.flush      = 1'b0;
        bus.resp_valid = 1'b1;
        chk("flush_wait_occ", int'(bus.occupancy), 1);
        step();
        bus.resp_valid = 1'b0;
        chk("flush_wait_resp_occ", int'(bus.occupancy), 0);

        // flush + resp + 3 lanes in one cycle.
        lanes(3'b011, 3'b011, 30, 31, 0);
        step();
        quiet();
        pend(30);
        step();
        bus.rob_pending_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready  = 1'b0;
        bus.flush      = 1'b1;
        bus.resp_valid = 1'b1;
        lanes(3'b111, 3'b111, 1, 2, 3);
        step();
        quiet();
        chk("combo_occ", int'(bus.occupancy), 0);
        chk("combo_valid", int'(bus.out_valid), 0);

        // Back in IDLE: a fresh entry issues, then flush in ISSUE drops it.
        lanes(3'b001, 3'b001, 33, 0, 0);
        step();
        quiet();
        pend(33);
        step();
        bus.rob_pending_valid = 1'b0;
        chk("idle_issue_idx", int'(bus.out_rob_idx), 33);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_issue_valid", int'(bus.out_valid), 0);
        chk("flush_issue_occ", int'(bus.occupancy), 0);

        // Duplicate robIdx: second copy stays for a later match.
        lanes(3'b011, 3'b011, 50, 50, 0);
        step();
        quiet();
        for (int k = 0; k < 2; k++) begin
            pend(50);
            step();
            bus.rob_pending_valid = 1'b0;
            chk("dup_idx", int'(bus.out_rob_idx), 50);
            bus.out_ready = 1'b1;
            step();
            bus.out_ready  = 1'b0;
            bus.resp_valid = 1'b1;
            step();
            bus.resp_valid = 1'b0;
            chk("dup_occ", int'(bus.occupancy), 1 - k);
        end

        // Asynchronous reset mid-ISSUE.
        lanes(3'b100, 3'b100, 0, 0, 60);
        step();
        quiet();
        pend(60);
        step();
        bus.rob_pending_valid = 1'b0;
        chk("pre_rst_valid", int'(bus.out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(bus.out_valid), 0);
        chk("async_rst_occ", int'(bus.occupancy), 0);
        chk("async_rst_ready", int'(bus.in_ready), 1);
        chk("async_rst_ovf", int'(bus.overflow_err), 0);
        step();
        rst = 1'b0;
        step();

        // A few back-to-back single-op transactions after reset.
        for (int k = 0; k < 4; k++) begin
            lanes(3'b001 << (k % 3), 3'b111, 70 + k, 70 + k, 70 + k);
            step();
            quiet();
            pend(70 + k);
            step();
            bus.rob_pending_valid = 1'b0;
            chk("loop_idx", int'(bus.out_rob_idx), 70 + k);
            bus.out_ready = 1'b1;
            step();
            bus.out_ready  = 1'b0;
            bus.resp_valid = 1'b1;
            step();
            bus.resp_valid = 1'b0;
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
